// File: rtl/wb_reg_slave.sv
// Wishbone classic register responder: CTRL/SCRATCH/COMPARE/COUNTER/STATUS/ID map
// with a configurable number of wait states ahead of the acknowledge.
// state | meaning
// IDLE  | waiting for cyc & stb; request captured here
// WAIT  | counting down wait states; dropped request aborts without commit
// ACK   | single-cycle acknowledge; request ignored
`timescale 1ns/1ps
module wb_reg_slave #(
    parameter int unsigned ACK_WAIT = 0,
    parameter logic [31:0] ID_VALUE = 32'h5742_0001
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [11:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o
);

    localparam logic [9:0] A_CTRL    = 10'h000;
    localparam logic [9:0] A_SCRATCH = 10'h001;
    localparam logic [9:0] A_COMPARE = 10'h002;
    localparam logic [9:0] A_COUNTER = 10'h040;
    localparam logic [9:0] A_STATUS  = 10'h041;
    localparam logic [9:0] A_ID      = 10'h07F;

    localparam logic [7:0] WAIT_LOAD = (ACK_WAIT > 0) ? 8'(ACK_WAIT - 1) : 8'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [9:0]  adr_q;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] dat_q;

    logic        en_q;
    logic [31:0] scratch_q;
    logic [31:0] compare_q;
    logic [31:0] counter;
    logic        match_q;

    logic        req;
    logic        capture;
    logic        commit;
    logic [9:0]  c_adr;
    logic        c_we;
    logic [3:0]  c_sel;
    logic [31:0] c_dat;
    logic        wr_ctrl, wr_scratch, wr_compare, wr_status;
    logic        clr_pulse, w1c, match_hit, rd_commit;
    logic [31:0] rd_data;

    logic        unused_adr_bits;
    assign unused_adr_bits = ^wb_adr_i[1:0];

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_val[8*b +: 8];
        end
        return r;
    endfunction

    assign req      = wb_cyc_i & wb_stb_i;
    assign wb_ack_o = (state_q == ST_ACK);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        capture    = 1'b0;
        commit     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    if (ACK_WAIT == 0) begin
                        commit  = 1'b1;
                        state_d = ST_ACK;
                    end else begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (wait_cnt_q == 8'd0) begin
                    commit  = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    wait_cnt_d = wait_cnt_q - 8'd1;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // With zero wait states the commit happens on the capture edge, so use the live bus.
    assign c_adr = (state_q == ST_IDLE) ? wb_adr_i[11:2] : adr_q;
    assign c_we  = (state_q == ST_IDLE) ? wb_we_i        : we_q;
    assign c_sel = (state_q == ST_IDLE) ? wb_sel_i       : sel_q;
    assign c_dat = (state_q == ST_IDLE) ? wb_dat_i       : dat_q;

    assign wr_ctrl    = commit & c_we & (c_adr == A_CTRL);
    assign wr_scratch = commit & c_we & (c_adr == A_SCRATCH);
    assign wr_compare = commit & c_we & (c_adr == A_COMPARE);
    assign wr_status  = commit & c_we & (c_adr == A_STATUS);
    assign rd_commit  = commit & ~c_we;
    assign clr_pulse  = wr_ctrl & c_sel[0] & c_dat[1];
    assign w1c        = wr_status & c_sel[0] & c_dat[0];
    assign match_hit  = en_q & (counter == compare_q);

    always_comb begin
        rd_data = 32'd0;
        case (c_adr)
            A_CTRL:    rd_data = {31'd0, en_q};
            A_SCRATCH: rd_data = scratch_q;
            A_COMPARE: rd_data = compare_q;
            A_COUNTER: rd_data = counter;
            A_STATUS:  rd_data = {31'd0, match_q};
            A_ID:      rd_data = ID_VALUE;
            default:   rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 8'd0;
            adr_q      <= 10'd0;
            we_q       <= 1'b0;
            sel_q      <= 4'd0;
            dat_q      <= 32'd0;
            en_q       <= 1'b0;
            scratch_q  <= 32'd0;
            compare_q  <= 32'hFFFF_FFFF;
            counter    <= 32'd0;
            match_q    <= 1'b0;
            wb_dat_o   <= 32'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (capture) begin
                adr_q <= wb_adr_i[11:2];
                we_q  <= wb_we_i;
                sel_q <= wb_sel_i;
                dat_q <= wb_dat_i;
            end
            if (wr_ctrl && c_sel[0]) en_q <= c_dat[0];
            if (wr_scratch) scratch_q <= byte_merge(scratch_q, c_dat, c_sel);
            if (wr_compare) compare_q <= byte_merge(compare_q, c_dat, c_sel);
            if (clr_pulse) begin
                counter <= 32'd0;
            end else if (en_q) begin
                counter <= counter + 32'd1;
            end
            // A fresh match outranks a simultaneous clear request.
            match_q <= match_hit | (match_q & ~w1c);
            if (rd_commit) wb_dat_o <= rd_data;
        end
    end

endmodule

// File: tb/tb_wb_reg_slave.sv
// Bench for wb_reg_slave: two instances (0 and 3 wait states) against a transaction-level
// register model, checked every cycle, plus directed literal expectations.
`timescale 1ns/1ps
module tb_wb_reg_slave;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [11:0] adr  [2];
    logic [31:0] dati [2];
    logic [31:0] dato [2];
    logic        we   [2];
    logic [3:0]  sel  [2];
    logic        stb  [2];
    logic        cyc  [2];
    logic        ack  [2];

    wb_reg_slave #(.ACK_WAIT(0), .ID_VALUE(32'h5742_0001)) u_dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr[0]), .wb_dat_i(dati[0]),
        .wb_dat_o(dato[0]), .wb_we_i(we[0]), .wb_sel_i(sel[0]), .wb_stb_i(stb[0]),
        .wb_cyc_i(cyc[0]), .wb_ack_o(ack[0]));

    wb_reg_slave #(.ACK_WAIT(3), .ID_VALUE(32'h5742_0001)) u_dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr[1]), .wb_dat_i(dati[1]),
        .wb_dat_o(dato[1]), .wb_we_i(we[1]), .wb_sel_i(sel[1]), .wb_stb_i(stb[1]),
        .wb_cyc_i(cyc[1]), .wb_ack_o(ack[1]));

    int n_err = 0;
    int n_chk = 0;

    // Model state: register contents plus the currently captured request.
    int          edge_n = 0;
    int          wlat     [2] = '{0, 3};
    logic [31:0] m_cnt    [2];
    logic [31:0] m_cmp    [2];
    logic [31:0] m_scr    [2];
    logic [31:0] m_dat    [2];
    logic        m_en     [2];
    logic        m_match  [2];
    logic        m_ack    [2];
    bit          pend     [2];
    int          commit_e [2];
    int          ack_e    [2] = '{0, 0};
    logic [9:0]  p_adr    [2];
    bit          p_we     [2];
    logic [3:0]  p_sel    [2];
    logic [31:0] p_dat    [2];
    int          force_seq  = 0;
    int          force_seen = 0;
    logic [31:0] force_val  = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    task automatic model_step(input int i);
        logic [31:0] o_cnt, o_cmp;
        logic        o_en, o_match, clr, w1c, req;
        req      = cyc[i] & stb[i];
        m_ack[i] = 1'b0;
        if (rst) begin
            m_en[i] = 1'b0; m_cnt[i] = 32'd0; m_cmp[i] = 32'hFFFF_FFFF;
            m_scr[i] = 32'd0; m_match[i] = 1'b0; m_dat[i] = 32'd0;
            pend[i] = 1'b0; ack_e[i] = edge_n;
            return;
        end
        if (i == 0 && force_seq != force_seen) begin
            m_cnt[0]   = force_val;
            force_seen = force_seq;
        end
        o_cnt = m_cnt[i]; o_cmp = m_cmp[i]; o_en = m_en[i]; o_match = m_match[i];
        clr = 1'b0; w1c = 1'b0;
        if (pend[i] && !req) begin
            pend[i] = 1'b0;
        end else if (!pend[i] && req && edge_n > ack_e[i]) begin
            pend[i]     = 1'b1;
            p_adr[i]    = adr[i][11:2];
            p_we[i]     = we[i];
            p_sel[i]    = sel[i];
            p_dat[i]    = dati[i];
            commit_e[i] = edge_n + wlat[i];
        end
        if (pend[i] && edge_n == commit_e[i]) begin
            pend[i]  = 1'b0;
            ack_e[i] = edge_n + 1;
            m_ack[i] = 1'b1;
            if (p_we[i]) begin
                case (p_adr[i])
                    10'h000: if (p_sel[i][0]) begin m_en[i] = p_dat[i][0]; clr = p_dat[i][1]; end
                    10'h001: m_scr[i] = merge(m_scr[i], p_dat[i], p_sel[i]);
                    10'h002: m_cmp[i] = merge(o_cmp, p_dat[i], p_sel[i]);
                    10'h041: w1c = p_sel[i][0] & p_dat[i][0];
                    default: ;
                endcase
            end else begin
                case (p_adr[i])
                    10'h000: m_dat[i] = {31'd0, o_en};
                    10'h001: m_dat[i] = m_scr[i];
                    10'h002: m_dat[i] = o_cmp;
                    10'h040: m_dat[i] = o_cnt;
                    10'h041: m_dat[i] = {31'd0, o_match};
                    10'h07F: m_dat[i] = 32'h5742_0001;
                    default: m_dat[i] = 32'd0;
                endcase
            end
        end
        m_cnt[i]   = clr ? 32'd0 : (o_en ? o_cnt + 32'd1 : o_cnt);
        m_match[i] = (o_en && o_cnt == o_cmp) || (o_match && !w1c);
    endtask

    initial forever begin
        @(posedge clk);
        edge_n++;
        for (int i = 0; i < 2; i++) model_step(i);
    end

    initial forever begin
        @(negedge clk);
        if (edge_n > 0) begin
            check("ack0", 32'(ack[0]), 32'(m_ack[0]));
            check("dat0", dato[0], m_dat[0]);
            check("ack1", 32'(ack[1]), 32'(m_ack[1]));
            check("dat1", dato[1], m_dat[1]);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; returns at posedge+1 after the ack cycle.
    task automatic xfer(input int i, input logic w, input logic [11:0] a, input logic [3:0] s,
                        input logic [31:0] d, output logic [31:0] rd, output int lat);
        cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w; adr[i] = a; sel[i] = s; dati[i] = d;
        lat = 0;
        while (1) begin
            @(negedge clk);
            if (ack[i]) break;
            lat++;
            if (lat > 400) begin
                check("ack_timeout", 32'd0, 32'd1);
                break;
            end
        end
        rd = dato[i];
        @(posedge clk); #1;
        cyc[i] = 1'b0; stb[i] = 1'b0;
    endtask

    task automatic do_wr(input int i, input logic [11:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        logic [31:0] rd;
        int lat;
        xfer(i, 1'b1, a, s, d, rd, lat);
    endtask

    task automatic do_rd(input int i, input logic [11:0] a, output logic [31:0] rd,
                         output int lat);
        xfer(i, 1'b0, a, 4'hF, 32'd0, rd, lat);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic abort_wr(input int i, input logic [11:0] a, input logic [31:0] d, input int k,
                            output logic saw);
        saw = 1'b0;
        cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = 1'b1; adr[i] = a; sel[i] = 4'hF; dati[i] = d;
        repeat (k) begin @(negedge clk); if (ack[i]) saw = 1'b1; @(posedge clk); end
        #1;
        stb[i] = 1'b0; cyc[i] = 1'b0;
        repeat (6) begin @(negedge clk); if (ack[i]) saw = 1'b1; end
        @(posedge clk); #1;
    endtask

    logic [31:0] rd, x;
    int          lat;
    logic        saw;
    logic [11:0] amap [8];

    initial begin
        amap = '{12'h000, 12'h004, 12'h008, 12'h100, 12'h104, 12'h1FC, 12'h200, 12'h000};
        for (int i = 0; i < 2; i++) begin
            cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
            adr[i] = 12'd0; sel[i] = 4'd0; dati[i] = 32'd0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", 32'(ack[0]), 32'd0);
        check("reset_dat", dato[0], 32'd0);
        rst = 1'b0;

        do_rd(0, 12'h1FC, rd, lat);
        check("id_value", rd, 32'h5742_0001);
        check("id_latency_w0", 32'(lat), 32'd1);
        do_rd(0, 12'h008, rd, lat);
        check("compare_reset", rd, 32'hFFFF_FFFF);
        do_wr(0, 12'h004, 32'hDEAD_BEEF, 4'b0101);
        do_rd(0, 12'h004, rd, lat);
        check("scratch_be", rd, 32'h00AD_00EF);
        do_rd(0, 12'h200, rd, lat);
        check("unmapped_read", rd, 32'd0);
        check("unmapped_latency", 32'(lat), 32'd1);

        do_wr(0, 12'h000, 32'h1, 4'hF);
        idle(10);
        do_wr(0, 12'h000, 32'h2, 4'hF);
        do_rd(0, 12'h100, rd, lat);
        check("counter_after_clr", 32'(rd < 32'd3), 32'd1);
        do_rd(0, 12'h000, rd, lat);
        check("ctrl_after_clr", rd, 32'd0);

        do_wr(0, 12'h008, 32'd5, 4'hF);
        do_wr(0, 12'h000, 32'h1, 4'hF);
        idle(10);
        do_rd(0, 12'h104, rd, lat);
        check("status_match", rd, 32'd1);
        do_wr(0, 12'h104, 32'h1, 4'hF);
        do_rd(0, 12'h104, rd, lat);
        check("status_w1c", rd, 32'd0);
        // The status write commits two edges after this compare write, so aim COMPARE there.
        x = m_cnt[0] + 32'd2;
        do_wr(0, 12'h008, x, 4'hF);
        do_wr(0, 12'h104, 32'h1, 4'hF);
        do_rd(0, 12'h104, rd, lat);
        check("status_set_wins", rd, 32'd1);

        do_wr(0, 12'h000, 32'h2, 4'hF);
        do_wr(0, 12'h008, 32'd0, 4'hF);
        do_wr(0, 12'h104, 32'h1, 4'hF);
        do_rd(0, 12'h104, rd, lat);
        check("status_cleared", rd, 32'd0);
        @(negedge clk);
        force u_dut0.counter = 32'hFFFF_FFF0;
        release u_dut0.counter;
        force_val = 32'hFFFF_FFF0;
        force_seq++;
        @(posedge clk); #1;
        do_wr(0, 12'h000, 32'h1, 4'hF);
        idle(25);
        do_rd(0, 12'h104, rd, lat);
        check("wrap_match", rd, 32'd1);
        do_rd(0, 12'h100, rd, lat);
        check("wrap_counter", 32'(rd < 32'd40), 32'd1);

        do_rd(1, 12'h1FC, rd, lat);
        check("id_value_w3", rd, 32'h5742_0001);
        check("id_latency_w3", 32'(lat), 32'd4);
        do_wr(1, 12'h004, 32'h1234_5678, 4'hF);
        abort_wr(1, 12'h004, 32'hFFFF_FFFF, 2, saw);
        check("abort_no_ack", 32'(saw), 32'd0);
        do_rd(1, 12'h004, rd, lat);
        check("abort_scratch", rd, 32'h1234_5678);

        for (int n = 0; n < 160; n++) begin
            int          i;
            logic [11:0] a;
            logic        w;
            logic [31:0] d;
            i = int'($urandom_range(0, 1));
            a = amap[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) a = 12'($urandom);
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            if (a == 12'h000) d = 32'($urandom_range(0, 3));
            if (a == 12'h008) d = m_cnt[i] + 32'($urandom_range(0, 12));
            if (a == 12'h104) d = 32'($urandom_range(0, 1));
            if (i == 1 && $urandom_range(0, 5) == 0) begin
                abort_wr(1, a, d, int'($urandom_range(1, 3)), saw);
                check("rand_abort_no_ack", 32'(saw), 32'd0);
            end else begin
                xfer(i, w, a, 4'($urandom), d, rd, lat);
                check("rand_latency", 32'(lat), 32'(wlat[i] + 1));
            end
            idle(int'($urandom_range(0, 2)));
        end

        do_wr(1, 12'h000, 32'h1, 4'hF);
        do_wr(1, 12'h008, 32'd7, 4'hF);
        do_wr(1, 12'h004, 32'hA5A5_5A5A, 4'hF);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 12'h004;
        sel[1] = 4'hF; dati[1] = 32'h0BAD_F00D;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cyc[1] = 1'b0; stb[1] = 1'b0;
        saw = 1'b0;
        repeat (6) begin @(negedge clk); if (ack[1]) saw = 1'b1; end
        @(posedge clk); #1;
        check("reset_no_ack", 32'(saw), 32'd0);
        do_rd(1, 12'h004, rd, lat);
        check("reset_scratch", rd, 32'd0);
        do_rd(1, 12'h008, rd, lat);
        check("reset_compare", rd, 32'hFFFF_FFFF);
        do_rd(1, 12'h000, rd, lat);
        check("reset_ctrl", rd, 32'd0);
        do_rd(1, 12'h104, rd, lat);
        check("reset_status", rd, 32'd0);
        do_rd(1, 12'h100, rd, lat);
        check("reset_counter", rd, 32'd0);
        do_rd(0, 12'h004, rd, lat);
        check("reset_scratch_w0", rd, 32'd0);

        idle(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_reg_slave.md
# wb_reg_slave

Wishbone classic responder for the 12-bit address / 32-bit data bus driven by the team's wishbone controller. Decodes a small register map: control, scratch, compare, a free-running 32-bit event counter, and a sticky compare-match status. Inserts a programmable number of wait states before acknowledging, so master-side ack handling can be exercised against non-zero slave latency.

## Interface
- `ACK_WAIT`, 0: wait-state cycles inserted between request capture and `wb_ack_o` (0–255).
- `ID_VALUE`, 32'h5742_0001: constant returned by the ID register.
- `wb_clk_i`  in  1  clock; all logic on rising edge.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `wb_adr_i`  in  12  byte address; `[1:0]` ignored, word-aligned decode on `[11:2]`.
- `wb_dat_i`  in  32  write data.
- `wb_dat_o`  out  32  read data, registered.
- `wb_we_i`  in  1  1 = write, 0 = read.
- `wb_sel_i`  in  4  byte enables; bit n covers `dat[8n+7:8n]`.
- `wb_stb_i`  in  1  strobe.
- `wb_cyc_i`  in  1  cycle valid.
- `wb_ack_o`  out  1  acknowledge, single-cycle pulse.

## Operation
- Request: `req = wb_cyc_i & wb_stb_i`.
- FSM states are IDLE, WAIT and ACK.
  - IDLE: on `req`, latch `adr`, `we`, `sel` and `dat`. Go to WAIT if `ACK_WAIT > 0` (load wait counter with `ACK_WAIT - 1`), else commit and go to ACK.
  - WAIT: if `req` drops, go to IDLE with no commit and no ack (abort). Otherwise decrement; at 0, commit and go to ACK.
  - ACK: `wb_ack_o = 1` for exactly this cycle, then IDLE unconditionally.
- Commit happens on the clock edge entering ACK:
  - Writes update their register.
  - Reads load `wb_dat_o`.
- Register map (byte addresses). Unmapped addresses read 0; writes to them are ignored but still acked.
  - 0x000 CTRL, RW:
    - bit0 EN, counter enable.
    - bit1 CLR: writing 1 clears the counter. Self-clearing, reads 0.
    - bits [31:2] read 0.
  - 0x004 SCRATCH, RW: 32-bit, byte-enable honoured.
  - 0x008 COMPARE, RW: 32-bit, byte-enable honoured.
  - 0x100 COUNTER, RO: value sampled at the commit edge, i.e. the pre-update value.
  - 0x104 STATUS: bit0 MATCH, sticky. Writing 1 to bit0 with `sel[0]` clears it.
  - 0x1FC ID, RO: returns `ID_VALUE`.
- Writes to RO registers are ignored.
- CTRL.EN and CTRL.CLR are taken from byte 0 only when `sel[0]` = 1.
- Counter update, in priority order:
  1. CLR write: counter = 0.
  2. Otherwise, when EN = 1: counter + 1 mod 2^32 (wraps 0xFFFF_FFFF → 0).
  3. Otherwise: hold.
- MATCH is set in any cycle where EN = 1 and counter == COMPARE, using pre-update values.
- MATCH set and W1C in the same cycle: set wins.
- `wb_dat_o` holds its last read value until the next read commit; it is unaffected by writes.

## Timing
- Reset values:
  - `wb_ack_o` = 0, `wb_dat_o` = 0, FSM = IDLE.
  - CTRL = 0, SCRATCH = 0, COMPARE = 0xFFFF_FFFF, COUNTER = 0, MATCH = 0.
- Latency is measured from the first cycle where `req` is sampled high in IDLE (cycle 0) to `wb_ack_o` high in cycle `ACK_WAIT + 1`. Data is valid in `wb_dat_o` in that same cycle.
- One transaction in flight. `req` is ignored in the ACK cycle.
- A master holding `req` high continuously gets a new transaction every `ACK_WAIT + 2` cycles.
- Reset asserted mid-transaction: the transfer is dropped, no ack is issued, and there is no commit on the reset edge.
- Aborting in WAIT leaves all registers unchanged.

## Test plan
- Reset, then read 0x1FC with `ACK_WAIT` = 0 → ack in cycle 1, `wb_dat_o` = 0x5742_0001. Read 0x008 → 0xFFFF_FFFF.
- Write 0x004 = 0xDEAD_BEEF with `sel` = 0b0101, then read back → 0x00AD_00EF. Read 0x200 (unmapped) → 0, acked.
- Write CTRL = 0x1, idle 10 cycles, then write CTRL = 0x2, then read 0x100 → small value (< 3). Confirm EN is cleared and CTRL reads 0x0.
- Write COMPARE = 5 and CTRL = 0x1 → STATUS reads 0x1 within 10 cycles. Write STATUS = 0x1 → reads 0x0, unless the counter matches in the same cycle, in which case it stays 0x1.
- `ACK_WAIT` = 3: read ack arrives exactly 4 cycles after capture. Drop `stb` in WAIT during a SCRATCH write → no ack, and SCRATCH is unchanged on readback.
- Force COUNTER near wrap (COMPARE = 0, preload via CLR plus many cycles or hierarchical force to 0xFFFF_FFFE) → wraps to 0, and MATCH is set at 0. Assert reset during WAIT → no ack, and all registers return to reset values.
